// File: rtl/bus_ctrl_pkg.sv
// Shared types and default widths for the bus transfer controller.
package bus_ctrl_pkg;

  localparam int BUS_DATA_WIDTH = 16;
  localparam int BUS_ADDR_WIDTH = 2;

  typedef enum logic [1:0] {
    OP_NOP      = 2'b00,
    OP_LOAD_IMM = 2'b01,
    OP_MOVE     = 2'b10,
    OP_READ     = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    READ_SRC  = 2'b01,
    WRITE_DST = 2'b10
  } state_e;

endpackage

// File: rtl/tri_state_buffer.sv
// Controller-side bus driver. On-chip buses are mux-based, so a disabled
// driver presents zero instead of high impedance.
module tri_state_buffer #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] data_in,
  input  logic             enable,
  output logic [WIDTH-1:0] data_out
);

  assign data_out = enable ? data_in : '0;

endmodule

// File: rtl/bus_transfer_controller.sv
// Sequences register-file transfers (load immediate, move, read) on a shared
// bus so that only one driver is ever active in a given cycle.
import bus_ctrl_pkg::*;

module bus_transfer_controller #(
  parameter int DATA_WIDTH = BUS_DATA_WIDTH,
  parameter int ADDR_WIDTH = BUS_ADDR_WIDTH
) (
  input  logic                  bus_controller_clock,
  input  logic                  bus_controller_reset_n,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  input  logic [1:0]            instr_op,
  input  logic [ADDR_WIDTH-1:0] instr_src,
  input  logic [ADDR_WIDTH-1:0] instr_dst,
  input  logic [DATA_WIDTH-1:0] instr_imm,
  input  logic [DATA_WIDTH-1:0] bus_in,
  output logic [DATA_WIDTH-1:0] bus_drive_data,
  output logic                  bus_drive_en,
  output logic [ADDR_WIDTH-1:0] reg_addr,
  output logic                  reg_in_en,
  output logic                  reg_out_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  done,
  output logic                  busy
);

  state_e                r_state;
  state_e                w_state_next;
  op_e                   r_op;
  op_e                   w_op_in;
  logic [ADDR_WIDTH-1:0] r_src;
  logic [ADDR_WIDTH-1:0] r_dst;
  logic [DATA_WIDTH-1:0] r_temp;
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic                  r_rd_valid;
  logic                  r_done;
  logic                  w_accept;
  logic                  w_drv_en;
  logic                  w_out_en;
  logic                  w_in_en;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_drv_data;

  // Ready is forced low while reset is held so nothing is accepted then.
  assign instr_ready = (r_state == IDLE) && bus_controller_reset_n;
  assign w_accept    = instr_valid && instr_ready;
  assign w_op_in     = op_e'(instr_op);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          case (w_op_in)
            OP_LOAD_IMM:     w_state_next = WRITE_DST;
            OP_MOVE, OP_READ: w_state_next = READ_SRC;
            default:         w_state_next = IDLE;
          endcase
        end
      end
      READ_SRC:  w_state_next = (r_op == OP_MOVE) ? WRITE_DST : IDLE;
      WRITE_DST: w_state_next = IDLE;
      default:   w_state_next = IDLE;
    endcase
  end

  // Enables come only from the state register, so the hand-over from the
  // register file to our driver happens on a single clock edge.
  always_comb begin
    w_drv_en = 1'b0;
    w_out_en = 1'b0;
    w_in_en  = 1'b0;
    w_addr   = '0;
    case (r_state)
      READ_SRC: begin
        w_out_en = 1'b1;
        w_addr   = r_src;
      end
      WRITE_DST: begin
        w_drv_en = 1'b1;
        w_in_en  = 1'b1;
        w_addr   = r_dst;
      end
      default: ;
    endcase
  end

  always_ff @(posedge bus_controller_clock or negedge bus_controller_reset_n) begin
    if (!bus_controller_reset_n) begin
      r_state    <= IDLE;
      r_op       <= OP_NOP;
      r_src      <= '0;
      r_dst      <= '0;
      r_temp     <= '0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_rd_valid <= 1'b0;
      r_done     <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_op  <= w_op_in;
            r_src <= instr_src;
            r_dst <= instr_dst;
            if (w_op_in == OP_LOAD_IMM) r_temp <= instr_imm;
            if (w_op_in == OP_NOP)      r_done <= 1'b1;
          end
        end
        READ_SRC: begin
          r_temp <= bus_in;
          if (r_op == OP_READ) begin
            r_rd_data  <= bus_in;
            r_rd_valid <= 1'b1;
            r_done     <= 1'b1;
          end
        end
        WRITE_DST: r_done <= 1'b1;
        default: ;
      endcase
    end
  end

  tri_state_buffer #(
    .WIDTH(DATA_WIDTH)
  ) u_bus_driver (
    .data_in (r_temp),
    .enable  (w_drv_en),
    .data_out(w_drv_data)
  );

  assign bus_drive_data = w_drv_data;
  assign bus_drive_en   = w_drv_en;
  assign reg_out_en     = w_out_en;
  assign reg_in_en      = w_in_en;
  assign reg_addr       = w_addr;
  assign rd_data        = r_rd_data;
  assign rd_valid       = r_rd_valid;
  assign done           = r_done;
  assign busy           = (r_state != IDLE);

endmodule

// File: tb/tb_bus_transfer_controller.sv
// Scoreboard bench: a behavioural register-file model predicts every phase,
// done pulse and read result; a monitor compares once per cycle.
module tb_bus_transfer_controller;
  import bus_ctrl_pkg::*;

  localparam int DW = 16;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          instr_valid = 1'b0;
  logic          instr_ready;
  logic [1:0]    instr_op = 2'b00;
  logic [AW-1:0] instr_src = '0;
  logic [AW-1:0] instr_dst = '0;
  logic [DW-1:0] instr_imm = '0;
  logic [DW-1:0] bus_in;
  logic [DW-1:0] bus_drive_data;
  logic          bus_drive_en;
  logic [AW-1:0] reg_addr;
  logic          reg_in_en;
  logic          reg_out_en;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          done;
  logic          busy;

  always #5 clk = ~clk;

  bus_transfer_controller #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .bus_controller_clock  (clk),
    .bus_controller_reset_n(rst_n),
    .instr_valid           (instr_valid),
    .instr_ready           (instr_ready),
    .instr_op              (instr_op),
    .instr_src             (instr_src),
    .instr_dst             (instr_dst),
    .instr_imm             (instr_imm),
    .bus_in                (bus_in),
    .bus_drive_data        (bus_drive_data),
    .bus_drive_en          (bus_drive_en),
    .reg_addr              (reg_addr),
    .reg_in_en             (reg_in_en),
    .reg_out_en            (reg_out_en),
    .rd_data               (rd_data),
    .rd_valid              (rd_valid),
    .done                  (done),
    .busy                  (busy)
  );

  // Register file on the shared bus (environment, not reset by the controller)
  logic [DW-1:0] rf [4] = '{default: '0};
  logic [DW-1:0] bus_val;
  always_comb begin
    bus_val = '0;
    if (bus_drive_en)    bus_val = bus_drive_data;
    else if (reg_out_en) bus_val = rf[reg_addr];
  end
  assign bus_in = bus_val;
  always @(posedge clk) if (reg_in_en) rf[reg_addr] <= bus_val;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [1:0]    op;
    logic [AW-1:0] src;
    logic [AW-1:0] dst;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    int            acc;
    int            stamp;
  } exp_t;

  exp_t          sbq[$];
  logic [DW-1:0] mregs [4];
  int            total = 0;
  int            bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Issue one instruction; returns at the negedge after the accepting edge.
  task automatic issue(input logic [1:0] op, input logic [AW-1:0] src,
                       input logic [AW-1:0] dst, input logic [DW-1:0] imm,
                       input bit scramble, output int acc);
    exp_t e;
    int   guard = 0;
    instr_valid = 1'b1;
    while (!instr_ready) begin
      if (scramble) begin
        instr_op  = 2'($urandom);
        instr_src = AW'($urandom);
        instr_dst = AW'($urandom);
        instr_imm = DW'($urandom);
      end
      @(negedge clk);
      guard++;
      if (guard > 50) begin
        $display("FAIL ready_timeout: instr_ready stuck low at cycle %0d", cyc);
        $fatal(1);
      end
    end
    instr_op  = op;
    instr_src = src;
    instr_dst = dst;
    instr_imm = imm;
    acc = cyc;
    e.op = op; e.src = src; e.dst = dst; e.wdata = '0; e.rdata = '0; e.acc = cyc;
    case (op)
      2'b01: begin e.wdata = imm; mregs[dst] = imm; e.stamp = cyc + 2; end
      2'b10: begin e.wdata = mregs[src]; mregs[dst] = mregs[src]; e.stamp = cyc + 3; end
      2'b11: begin e.rdata = mregs[src]; e.stamp = cyc + 2; end
      default: e.stamp = cyc + 1;
    endcase
    $display("issue op=%0d src=%0d dst=%0d imm=%04h at cycle %0d", op, src, dst, imm, cyc);
    @(posedge clk);
    sbq.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    instr_valid = 1'b0;
    instr_op    = 2'($urandom);
    instr_imm   = DW'($urandom);
    repeat (n) @(negedge clk);
  endtask

  task automatic drain();
    int g = 0;
    instr_valid = 1'b0;
    while (sbq.size() > 0 && g < 30) begin
      @(negedge clk);
      g++;
    end
    chk("drain", sbq.size(), 0);
  endtask

  // Monitor: expected outputs follow from the head transaction's age
  logic [DW-1:0] last_rd = '0;
  initial begin
    exp_t h;
    bit   have, e_out, e_drv, e_done, e_busy, e_rdv;
    int   ph;
    logic [AW-1:0] e_addr;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        last_rd = '0;
      end else begin
        have = sbq.size() > 0;
        if (have) h = sbq[0];
        ph     = have ? cyc - h.acc : 0;
        e_out  = have && ph == 1 && (h.op == 2'b10 || h.op == 2'b11);
        e_drv  = have && ((h.op == 2'b01 && ph == 1) || (h.op == 2'b10 && ph == 2));
        e_addr = e_out ? h.src : (e_drv ? h.dst : '0);
        e_done = have && cyc == h.stamp;
        e_busy = have && cyc < h.stamp && h.op != 2'b00;
        e_rdv  = e_done && h.op == 2'b11;
        chk("contention", 32'(reg_out_en & bus_drive_en), 0);
        chk("reg_out_en", 32'(reg_out_en), 32'(e_out));
        chk("bus_drive_en", 32'(bus_drive_en), 32'(e_drv));
        chk("reg_in_en", 32'(reg_in_en), 32'(e_drv));
        chk("reg_addr", 32'(reg_addr), 32'(e_addr));
        chk("busy", 32'(busy), 32'(e_busy));
        chk("instr_ready", 32'(instr_ready), 32'(!e_busy));
        chk("done", 32'(done), 32'(e_done));
        chk("rd_valid", 32'(rd_valid), 32'(e_rdv));
        if (e_drv) chk("bus_drive_data", 32'(bus_drive_data), 32'(h.wdata));
        if (e_rdv) last_rd = h.rdata;
        chk("rd_data", 32'(rd_data), 32'(last_rd));
        if (e_done) begin
          $display("retire op=%0d at cycle %0d rd_data=%04h", h.op, cyc, rd_data);
          void'(sbq.pop_front());
        end
      end
    end
  end

  initial begin
    int a0, a1, a2, a3, d;
    logic [DW-1:0] save_r1;
    for (int i = 0; i < 4; i++) mregs[i] = '0;

    // Reset state
    #1;
    chk("rst_ready", 32'(instr_ready), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_rd_valid", 32'(rd_valid), 0);
    chk("rst_rd_data", 32'(rd_data), 0);
    chk("rst_enables", 32'({bus_drive_en, reg_in_en, reg_out_en}), 0);
    chk("rst_reg_addr", 32'(reg_addr), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 32'(instr_ready), 1);

    // Directed sequences
    issue(2'b01, 2'd0, 2'd2, 16'hBEEF, 0, d);
    issue(2'b11, 2'd2, 2'd0, 16'h0000, 0, d);
    idle(2);
    issue(2'b01, 2'd0, 2'd1, 16'h1234, 0, d);
    issue(2'b10, 2'd1, 2'd3, 16'h0000, 0, a0);
    issue(2'b11, 2'd3, 2'd0, 16'h0000, 0, a1);
    chk("move_throughput", 32'(a1 - a0), 3);
    issue(2'b01, 2'd0, 2'd0, 16'h00FF, 0, d);
    issue(2'b10, 2'd0, 2'd0, 16'h0000, 0, d);
    issue(2'b11, 2'd0, 2'd0, 16'h0000, 0, d);
    drain();

    // Back-to-back with valid held high
    issue(2'b01, 2'd0, 2'd1, 16'h5A5A, 0, a0);
    issue(2'b10, 2'd1, 2'd2, 16'h0000, 0, a1);
    issue(2'b11, 2'd2, 2'd0, 16'h0000, 0, a2);
    issue(2'b00, 2'd0, 2'd0, 16'h0000, 0, a3);
    chk("b2b_load_to_move", 32'(a1 - a0), 2);
    chk("b2b_move_to_read", 32'(a2 - a1), 3);
    chk("b2b_read_to_nop", 32'(a3 - a2), 2);
    drain();

    // Garbage fields while not ready must be ignored
    issue(2'b10, 2'd2, 2'd3, 16'h0000, 1, d);
    issue(2'b11, 2'd3, 2'd0, 16'h0000, 1, d);
    drain();

    // Randomized traffic
    for (int n = 0; n < 150; n++) begin
      issue(2'($urandom), AW'($urandom), AW'($urandom), DW'($urandom), bit'($urandom), d);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end
    drain();

    // Reset in the READ_SRC cycle of a MOVE abandons it
    issue(2'b01, 2'd0, 2'd1, 16'hAAAA, 0, d);
    issue(2'b01, 2'd0, 2'd0, 16'h5555, 0, d);
    drain();
    save_r1 = mregs[1];
    issue(2'b10, 2'd0, 2'd1, 16'h0000, 0, d);
    instr_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    sbq.delete();
    mregs[1] = save_r1;
    #1;
    chk("midrst_enables", 32'({bus_drive_en, reg_in_en, reg_out_en}), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_ready", 32'(instr_ready), 0);
    chk("midrst_done", 32'(done), 0);
    chk("midrst_rd_data", 32'(rd_data), 0);
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_r1_kept", 32'(rf[1]), 32'h0000_AAAA);
    issue(2'b11, 2'd1, 2'd0, 16'h0000, 0, d);
    issue(2'b11, 2'd0, 2'd0, 16'h0000, 0, d);
    drain();

    for (int i = 0; i < 4; i++) chk($sformatf("final_r%0d", i), 32'(rf[i]), 32'(mregs[i]));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
